// File: rtl/mmm_exp_datapath.sv
// Modular-exponentiation datapath: computes M^e mod N (right-to-left binary)
// with two bit-serial Montgomery cores, core1 = X*B and core2 = P*P.
// A control unit sequences it through strobes.
//
// Handshake: there is no valid/ready pair. Every strobe (ld_a, ld_r, eoc,
// rst_mmm) is a single-cycle command that is sampled on a rising edge where
// en=1. The controller must allow ITER cycles after ld_a before it asserts
// ld_r or eoc.
//
// Optional macro RSA_DP_ERRCHK_EN adds a sticky protocol-error flag on err.
// When the macro is not defined, err is tied to 0.

module mmm_exp_core #(
   parameter int WIDTH = 8,
   parameter int ITER  = 10
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             en,
   input  logic             clr_n,
   input  logic             load,
   input  logic [WIDTH+1:0] a_in,
   input  logic [WIDTH+1:0] b_in,
   input  logic [WIDTH-1:0] mod_n,
   output logic [WIDTH+1:0] t_out,
   output logic             running
);
   // T needs one bit above 2N of headroom. While the loop runs, T stays
   // below B+N, which can reach 3N. Only the final value is below 2N.
   localparam int TW = WIDTH + 2;
   localparam int CW = $clog2(ITER + 1);
   localparam logic [CW-1:0] ITER_LAST = CW'(ITER - 1);

   logic [TW-1:0] t_q;
   logic [TW-1:0] a_q;
   logic [TW-1:0] b_q;
   logic [CW-1:0] cnt_q;
   logic          run_q;
   logic [TW:0]   s_sum;
   logic [TW:0]   s_red;
   logic [TW-1:0] t_nxt;

   // One radix-2 Montgomery step: add A[0]*B, make it even with q*N, halve
   always_comb begin
      s_sum = {1'b0, t_q} + (a_q[0] ? {1'b0, b_q} : '0);
      s_red = s_sum + (s_sum[0] ? {3'b000, mod_n} : '0);
      t_nxt = s_red[TW:1];
   end

   // Operand load, iteration and the saturating iteration count
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         t_q   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (en) begin
         if (!clr_n) begin
            t_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
         end else if (load) begin
            a_q   <= a_in;
            b_q   <= b_in;
            t_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
         end else if (run_q) begin
            t_q   <= t_nxt;
            a_q   <= a_q >> 1;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == ITER_LAST) run_q <= 1'b0;
         end
      end
   end

   assign t_out   = t_q;
   assign running = run_q;
endmodule

module mmm_exp_datapath #(
   parameter int WIDTH = 8,
   parameter int ITER  = 10
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             en,
   input  logic             rst_mmm,
   input  logic             ld_a,
   input  logic             ld_r,
   input  logic             lock1,
   input  logic             lock2,
   input  logic [1:0]       sel1,
   input  logic             sel2,
   input  logic             eoc,
   input  logic [WIDTH-1:0] msg_m,
   input  logic [WIDTH-1:0] mod_n,
   input  logic [WIDTH-1:0] const_r2,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             err
);
   localparam int TW = WIDTH + 2;
   localparam logic [TW-1:0] ONE = TW'(1);

   logic [TW-1:0]    x_q;
   logic [TW-1:0]    p_q;
   logic [TW-1:0]    a1;
   logic [TW-1:0]    b1;
   logic [TW-1:0]    a2;
   logic [TW-1:0]    b2;
   logic [TW-1:0]    t1;
   logic [TW-1:0]    t2;
   logic             run1;
   logic             run2;
   logic [WIDTH-1:0] result_q;
   logic             done_q;
   logic             t1_ge_n;
   logic [WIDTH-1:0] t1_red;

   // Core operand selection
   always_comb begin
      a1 = {x_q};
      b1 = ONE;
      case (sel1)
         2'b00: begin
            a1 = {2'b00, const_r2};
            b1 = ONE;
         end
         2'b01: begin
            a1 = x_q;
            b1 = p_q;
         end
         default: begin
            a1 = x_q;
            b1 = ONE;
         end
      endcase
      a2 = sel2 ? p_q : {2'b00, msg_m};
      b2 = sel2 ? p_q : {2'b00, const_r2};
   end

   mmm_exp_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core1 (
      .clk     (clk),
      .rstb    (rstb),
      .en      (en),
      .clr_n   (rst_mmm),
      .load    (ld_a),
      .a_in    (a1),
      .b_in    (b1),
      .mod_n   (mod_n),
      .t_out   (t1),
      .running (run1)
   );

   mmm_exp_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core2 (
      .clk     (clk),
      .rstb    (rstb),
      .en      (en),
      .clr_n   (rst_mmm),
      .load    (ld_a),
      .a_in    (a2),
      .b_in    (b2),
      .mod_n   (mod_n),
      .t_out   (t2),
      .running (run2)
   );

   // Final conditional subtract. The true result fits in WIDTH bits, so
   // subtracting modulo 2^WIDTH is exact.
   always_comb begin
      t1_ge_n = (t1 >= {2'b00, mod_n});
      t1_red  = t1[WIDTH-1:0] - (t1_ge_n ? mod_n : '0);
   end

   // Running result X, power P, output result and done flag
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         x_q      <= '0;
         p_q      <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else if (en) begin
         if (ld_r && lock1) x_q <= t1;
         if (ld_r && lock2) p_q <= t2;
         if (eoc) begin
            result_q <= t1_red;
            done_q   <= 1'b1;
         end else if (ld_a && !sel2) begin
            done_q <= 1'b0;
         end
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = run1 | run2;

`ifdef RSA_DP_ERRCHK_EN
   logic err_q;
   logic bad_sel_q;

   // Sticky error: ld_r before cores finished, or reserved sel1 at ld_a
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         err_q     <= 1'b0;
         bad_sel_q <= 1'b0;
      end else if (en) begin
         if (ld_a) bad_sel_q <= (sel1 == 2'b11);
         if (ld_r && (run1 || run2 || bad_sel_q)) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mmm_exp_datapath.sv
// Self-checking bench for mmm_exp_datapath. It drives full exponentiation
// sequences the way the control unit would. Each result is compared with
// M^e mod N, which the bench computes by plain square-and-multiply.
module tb_mmm_exp_datapath;
   localparam int WIDTH = 8;
   localparam int ITER  = 10;
   localparam int EBITS = 8;
`ifdef RSA_DP_ERRCHK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rstb = 1'b0;
   logic             en = 1'b1;
   logic             rst_mmm = 1'b1;
   logic             ld_a = 1'b0;
   logic             ld_r = 1'b0;
   logic             lock1 = 1'b0;
   logic             lock2 = 1'b0;
   logic [1:0]       sel1 = 2'b00;
   logic             sel2 = 1'b0;
   logic             eoc = 1'b0;
   logic [WIDTH-1:0] msg_m = '0;
   logic [WIDTH-1:0] mod_n = '0;
   logic [WIDTH-1:0] const_r2 = '0;
   logic [WIDTH-1:0] result;
   logic             done;
   logic             busy;
   logic             err;

   int total = 0;
   int bad = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] last_result = '0;

   // clock
   always #5 clk = ~clk;

   mmm_exp_datapath #(.WIDTH(WIDTH), .ITER(ITER)) dut (
      .clk      (clk),
      .rstb     (rstb),
      .en       (en),
      .rst_mmm  (rst_mmm),
      .ld_a     (ld_a),
      .ld_r     (ld_r),
      .lock1    (lock1),
      .lock2    (lock2),
      .sel1     (sel1),
      .sel2     (sel2),
      .eoc      (eoc),
      .msg_m    (msg_m),
      .mod_n    (mod_n),
      .const_r2 (const_r2),
      .result   (result),
      .done     (done),
      .busy     (busy),
      .err      (err)
   );

   // watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", tag, got, want);
      end
   endtask

   // reference model: plain square-and-multiply on integers
   function automatic int ref_modexp(input int m, input int n, input int e);
      longint acc = 1;
      longint base = longint'(m) % n;
      for (int i = 0; i < EBITS; i++) begin
         if (((e >> i) & 1) != 0) acc = (acc * base) % n;
         base = (base * base) % n;
      end
      return int'(acc % n);
   endfunction

   function automatic int ref_r2(input int n);
      longint r = longint'(1) << ITER;
      return int'((r * r) % n);
   endfunction

   // one 12-cycle control slot (plus optional freeze / extra idle cycles)
   task automatic slot(input logic [1:0] s1, input logic s2, input logic l1, input logic l2,
                       input logic fin, input bit freeze, input bit abort);
      sel1 = s1;
      sel2 = s2;
      ld_a = 1'b1;
      @(negedge clk);
      ld_a = 1'b0;
      check("busy_start", 32'(busy), 32'd1);
      repeat (4) @(negedge clk);
      if (abort) begin
         rstb = 1'b0;
         #1;
         check("abort_result", 32'(result), 32'd0);
         check("abort_done", 32'(done), 32'd0);
         check("abort_busy", 32'(busy), 32'd0);
         check("abort_err", 32'(err), 32'd0);
         @(negedge clk);
         rstb = 1'b1;
         @(negedge clk);
         return;
      end
      if (freeze) begin
         en = 1'b0;
         repeat (5) @(negedge clk);
         check("frozen_busy", 32'(busy), 32'd1);
         check("frozen_done", 32'(done), 32'd0);
         en = 1'b1;
      end
      repeat (ITER - 4 + $urandom_range(2, 0)) @(negedge clk);
      check("busy_end", 32'(busy), 32'd0);
      lock1 = l1;
      lock2 = l2;
      ld_r  = 1'b1;
      eoc   = fin;
      @(negedge clk);
      ld_r  = 1'b0;
      eoc   = 1'b0;
      lock1 = 1'b0;
      lock2 = 1'b0;
   endtask

   // full exponentiation sequence; expected value pushed to the scoreboard
   task automatic run_exp(input int m, input int n, input int e, input int freeze_slot,
                          input int abort_slot);
      logic [1:0] s1;
      logic       s2, l1, l2, fin;
      logic [WIDTH-1:0] want;
      msg_m    = WIDTH'(m);
      mod_n    = WIDTH'(n);
      const_r2 = WIDTH'(ref_r2(n));
      exp_q.push_back(WIDTH'(ref_modexp(m, n, e)));
      for (int idx = 0; idx < EBITS + 2; idx++) begin
         if (idx == 0) begin
            s1 = 2'b00; s2 = 1'b0; l1 = 1'b1; l2 = 1'b1; fin = 1'b0;
         end else if (idx <= EBITS) begin
            s1 = 2'b01; s2 = 1'b1; l1 = (((e >> (idx - 1)) & 1) != 0); l2 = 1'b1; fin = 1'b0;
         end else begin
            s1 = 2'b10; s2 = 1'b1; l1 = 1'b0; l2 = 1'b0; fin = 1'b1;
         end
         slot(s1, s2, l1, l2, fin, idx == freeze_slot, idx == abort_slot);
         if (idx == abort_slot) begin
            void'(exp_q.pop_back());
            return;
         end
         if (idx == 0) check("done_clr", 32'(done), 32'd0);
      end
      want = exp_q.pop_front();
      check("result", 32'(result), 32'(want));
      check("done_set", 32'(done), 32'd1);
      check("err_legal", 32'(err), 32'd0);
      last_result = want;
   endtask

   initial begin
      int n, m, e;
      // reset
      rstb = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_result", 32'(result), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rstb = 1'b1;
      @(negedge clk);

      // directed cases: textbook RSA values, e = 7, 0, 1
      run_exp(88, 187, 7, -1, -1);
      check("known_88_7", 32'(result), 32'd11);
      run_exp(88, 187, 0, -1, -1);
      run_exp(88, 187, 1, -1, -1);
      // enable freeze in the middle of a multiply
      run_exp(88, 187, 7, 3, -1);
      // reset pulse in slot 4, then a clean rerun
      run_exp(88, 187, 7, -1, 4);
      run_exp(88, 187, 7, -1, -1);

      // random operands
      for (int k = 0; k < 8; k++) begin
         n = 2 * $urandom_range(127, 1) + 1;
         m = $urandom_range(n - 1, 0);
         e = $urandom_range(255, 0);
         run_exp(m, n, e, -1, -1);
      end

      // core clear mid-multiply: cores stop, result and done are untouched
      sel1 = 2'b01;
      sel2 = 1'b1;
      ld_a = 1'b1;
      @(negedge clk);
      ld_a = 1'b0;
      @(negedge clk);
      check("mmm_busy_pre", 32'(busy), 32'd1);
      rst_mmm = 1'b0;
      @(negedge clk);
      rst_mmm = 1'b1;
      check("mmm_busy_post", 32'(busy), 32'd0);
      check("mmm_done_hold", 32'(done), 32'd1);
      check("mmm_result_hold", 32'(result), 32'(last_result));

      // protocol error: ld_r only 3 cycles after ld_a
      ld_a = 1'b1;
      @(negedge clk);
      ld_a = 1'b0;
      repeat (2) @(negedge clk);
      ld_r = 1'b1;
      @(negedge clk);
      ld_r = 1'b0;
      check("err_early_ldr", 32'(err), 32'(ERR_EXP));
      repeat (ITER) @(negedge clk);
      check("err_sticky", 32'(err), 32'(ERR_EXP));
      rstb = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      check("err_rst", 32'(err), 32'd0);
      @(negedge clk);

      // protocol error: reserved sel1 at ld_a, otherwise legal timing
      slot(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("err_sel11", 32'(err), 32'(ERR_EXP));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
